deserializer: RTL and testbench
===============================

Name: deserializer

Overview:
- Receive-side counterpart of the 16-bit serializer. Collects the MSB-first bit stream (ser_data, ser_data_val, busy) back into a word plus its valid-bit count, reproducing the serializer's data/data_mod input pair.
- Sits at the far end of the serial link and feeds the parallel consumer. It also closes the loopback path used in serializer/deserializer regression.

Parameters:
DATA_W, 16, parallel word width and maximum frame length in bits
MOD_W, 4, width of the count field, $clog2(DATA_W); a count of DATA_W is encoded as 0

Ports:
clk_150m  in  1  system clock, single clock domain
arst_i  in  1  reset, asynchronous, active-high; one clock; reset is asynchronous and active-high
ser_data_i  in  1  serial data bit, valid when ser_data_val_i=1
ser_data_val_i  in  1  bit strobe; each high cycle carries one bit
busy_i  in  1  frame envelope from the transmitter; high while a frame is in flight
deser_data_o  out  DATA_W  received word, left-justified; first bit received is at bit DATA_W-1; unused LSBs are 0
deser_data_mod_o  out  MOD_W  number of valid bits; 0 means DATA_W
deser_data_val_o  out  1  one-cycle strobe qualifying deser_data_o and deser_data_mod_o
err_o  out  1  one-cycle strobe: a short frame (1 or 2 bits) was discarded

Behaviour:
- Reset (async assert, release synchronous to clk_150m):
  - All outputs are 0, the bit counter is 0, the shift register is 0, and the FSM is in IDLE.
  - Reset asserted mid-frame discards the partial frame with no strobe.
- Bit acceptance:
  - Every rising edge with ser_data_val_i=1 accepts one bit into position DATA_W-1-cnt, then cnt increments.
  - Acceptance is independent of busy_i.
- FSM states:
  - IDLE: cnt=0. An accepted bit moves to RECV.
  - RECV: collecting bits.
    - Close on the edge where the DATA_W-th bit is accepted (full close). This happens regardless of busy_i.
    - Otherwise close on the first edge sampling busy_i=0 AND ser_data_val_i=0 with cnt>0 (envelope close).
    - ser_data_val_i=0 while busy_i=1 is a gap: stay in RECV and hold cnt.
  - On close the state returns to IDLE, cnt clears and the shift register clears.
- Output timing:
  - Outputs are registered. Strobes assert in the cycle after the closing edge, for exactly one cycle.
  - deser_data_o and deser_data_mod_o hold their last value until the next strobe and are not cleared after the strobe.
- Count mapping:
  - cnt=16 gives mod 0.
  - cnt 3..15 gives mod=cnt.
  - cnt 1..2 means the frame is dropped: deser_data_val_o stays 0, err_o pulses, and the data/mod outputs are unchanged. The serializer never emits these frame lengths.
- Simultaneous events:
  - A bit arriving in the strobe cycle belongs to the next frame. Back-to-back frames need no idle cycle.
  - After a full close with busy_i still high, trailing busy cycles with no valid bit are ignored (cnt=0, no close).
- Width rule: cnt is MOD_W+1 bits wide and never exceeds DATA_W.
- Latency: the last accepted bit or the busy_i fall is followed by the strobe 1 clock later.

Decomposition:
- Package deser_pkg holds:
  - DATA_W and MOD_W defaults
  - state enum (IDLE, RECV)
  - short-frame threshold constant MIN_LEN=3
- Single module, no sub-module.
- Loopback bench wrapper (serializer_top feeding deserializer) lives in tb only.

Test Plan:
- 16 bits of 16'hAAAA MSB-first with busy_i high, then busy_i low -> strobe 1 cycle after the 16th bit; deser_data_o=16'hAAAA, deser_data_mod_o=0; no second strobe on the busy_i fall.
- 5 bits 1,0,1,1,0, then busy_i=0 -> deser_data_o=16'hB000, deser_data_mod_o=5, strobe one cycle after the busy_i fall.
- Bits 1,1,1 with 2-cycle gaps (ser_data_val_i=0, busy_i=1) between them -> one strobe only after busy_i falls; deser_data_o=16'hE000, deser_data_mod_o=3.
- 2-bit frame 1,1 -> err_o 1-cycle pulse; deser_data_val_o stays 0; previous deser_data_o is unchanged.
- arst_i pulse after 7 bits of a frame -> no strobe and all outputs 0. A following full frame 16'h1234 is received exactly (data_o=16'h1234, mod=0).
- Loopback with serializer_top:
  - 16'hFFFF mod 0, 16'h0000 mod 0, 16'hFEDC mod 1 (expect nothing), plus 50 random data/mod/valid frames.
  - Each accepted frame must reproduce data[15:16-len] with matching mod; frames with mod 1/2 or invalid input produce no strobe.

Source files
------------

// File: rtl/deser_pkg.sv
// deser_pkg: shared widths, FSM state type and short-frame threshold for the deserializer
package deser_pkg;
    localparam int DATA_W  = 16;
    localparam int MOD_W   = $clog2(DATA_W);
    localparam int MIN_LEN = 3;
    typedef enum logic {IDLE, RECV} state_t;
endpackage

// File: rtl/deserializer_if.sv
// deserializer_if: serial link inputs and parallel word outputs of the deserializer
interface deserializer_if #(
    parameter int DATA_W = deser_pkg::DATA_W,
    parameter int MOD_W  = deser_pkg::MOD_W
);
    logic              ser_data_i;
    logic              ser_data_val_i;
    logic              busy_i;
    logic [DATA_W-1:0] deser_data_o;
    logic [MOD_W-1:0]  deser_data_mod_o;
    logic              deser_data_val_o;
    logic              err_o;
    modport master (
        output ser_data_i, ser_data_val_i, busy_i,
        input  deser_data_o, deser_data_mod_o, deser_data_val_o, err_o
    );
    modport slave (
        input  ser_data_i, ser_data_val_i, busy_i,
        output deser_data_o, deser_data_mod_o, deser_data_val_o, err_o
    );
endinterface

// File: rtl/deserializer.sv
// deserializer: rebuilds an MSB-first serial frame into a left-justified word plus valid-bit count
module deserializer
    import deser_pkg::state_t, deser_pkg::IDLE, deser_pkg::RECV, deser_pkg::MIN_LEN;
#(
    parameter int DATA_W = deser_pkg::DATA_W,
    parameter int MOD_W  = deser_pkg::MOD_W
) (
    input logic           clk_150m,
    input logic           arst_i,
    deserializer_if.slave bus
);
    localparam int CW = MOD_W + 1;
    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n, fin_cnt;
    logic [DATA_W-1:0] sh, sh_n, sh_acc, data_q, data_n;
    logic [MOD_W-1:0]  mod_q, mod_n, pos;
    logic              val_q, val_n, err_q, err_n, full, close, keep;
    assign pos     = MOD_W'(DATA_W - 1) - cnt[MOD_W-1:0];
    assign sh_acc  = bus.ser_data_val_i ? sh | (DATA_W'(bus.ser_data_i) << pos) : sh;
    assign full    = bus.ser_data_val_i && cnt == CW'(DATA_W - 1);
    // a gap (no strobe while busy) holds the frame; only busy low with no bit closes it
    assign close   = full || (state == RECV && cnt != '0 && !bus.busy_i && !bus.ser_data_val_i);
    assign fin_cnt = full ? CW'(DATA_W) : cnt;
    assign keep    = fin_cnt >= CW'(MIN_LEN);
    always_comb begin
        state_n = close ? IDLE : (bus.ser_data_val_i ? RECV : state);
        cnt_n   = close ? '0 : cnt + CW'(bus.ser_data_val_i);
        sh_n    = close ? '0 : sh_acc;
        data_n  = close && keep ? sh_acc : data_q;
        mod_n   = close && keep ? fin_cnt[MOD_W-1:0] : mod_q;
        val_n   = close && keep;
        err_n   = close && !keep;
    end
    always_ff @(posedge clk_150m or posedge arst_i) begin
        if (arst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            sh     <= '0;
            data_q <= '0;
            mod_q  <= '0;
            val_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            sh     <= sh_n;
            data_q <= data_n;
            mod_q  <= mod_n;
            val_q  <= val_n;
            err_q  <= err_n;
        end
    end
    assign bus.deser_data_o     = data_q;
    assign bus.deser_data_mod_o = mod_q;
    assign bus.deser_data_val_o = val_q;
    assign bus.err_o            = err_q;
endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: directed frames plus a serializer-level loopback model checked against observed strobes
module tb_deserializer;
    logic clk_150m = 1'b0;
    logic arst_i   = 1'b1;
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    typedef struct {
        int          c;
        logic        v;
        logic        e;
        logic [15:0] d;
        logic [3:0]  m;
    } ev_t;
    ev_t act_q[$];
    ev_t exp_q[$];
    always #3 clk_150m = ~clk_150m;
    deserializer_if bus();
    deserializer dut (.clk_150m(clk_150m), .arst_i(arst_i), .bus(bus.slave));
    always @(posedge clk_150m) cyc <= cyc + 1;
    always @(negedge clk_150m)
        if (!arst_i && (bus.deser_data_val_o || bus.err_o))
            act_q.push_back('{cyc, bus.deser_data_val_o, bus.err_o, bus.deser_data_o, bus.deser_data_mod_o});

    // returns the index of the clock edge that samples the driven values
    task automatic step(input logic v, input logic b, input logic bsy, output int e);
        @(negedge clk_150m);
        bus.ser_data_val_i = v;
        bus.ser_data_i     = b;
        bus.busy_i         = bsy;
        e = cyc + 1;
    endtask

    task automatic idle(input int n);
        int e;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, e);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk_150m);
        checks += 4;
        if (bus.deser_data_o !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0000", bus.deser_data_o); end
        if (bus.deser_data_mod_o !== 4'h0) begin errors++; $display("FAIL reset_mod got %h want 0", bus.deser_data_mod_o); end
        if (bus.deser_data_val_o !== 1'b0) begin errors++; $display("FAIL reset_val got %b want 0", bus.deser_data_val_o); end
        if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err_o); end
        arst_i = 1'b0;
        idle(2);
    endtask

    task automatic test_full;
        logic [15:0] w = 16'hAAAA;
        int e, ef;
        act_q.delete();
        for (int i = 0; i < 16; i++) step(1'b1, w[15-i], 1'b1, e);
        ef = e;
        step(1'b0, 1'b0, 1'b1, e);
        step(1'b0, 1'b0, 1'b1, e);
        idle(4);
        checks++;
        if (act_q.size() !== 1) begin errors++; $display("FAIL full_count got %0d want 1", act_q.size()); end
        if (act_q.size() > 0) begin
            checks += 4;
            if (act_q[0].c !== ef) begin errors++; $display("FAIL full_cycle got %0d want %0d", act_q[0].c, ef); end
            if (act_q[0].v !== 1'b1 || act_q[0].e !== 1'b0) begin errors++; $display("FAIL full_kind got v%b e%b want v1 e0", act_q[0].v, act_q[0].e); end
            if (act_q[0].d !== 16'hAAAA) begin errors++; $display("FAIL full_data got %h want aaaa", act_q[0].d); end
            if (act_q[0].m !== 4'd0) begin errors++; $display("FAIL full_mod got %0d want 0", act_q[0].m); end
        end
    endtask

    task automatic test_five;
        logic [4:0] b = 5'b10110;
        int e, ef;
        act_q.delete();
        for (int i = 0; i < 5; i++) step(1'b1, b[4-i], 1'b1, e);
        step(1'b0, 1'b0, 1'b0, ef);
        idle(3);
        checks++;
        if (act_q.size() !== 1) begin errors++; $display("FAIL five_count got %0d want 1", act_q.size()); end
        if (act_q.size() > 0) begin
            checks += 3;
            if (act_q[0].c !== ef) begin errors++; $display("FAIL five_cycle got %0d want %0d", act_q[0].c, ef); end
            if (act_q[0].d !== 16'hB000) begin errors++; $display("FAIL five_data got %h want b000", act_q[0].d); end
            if (act_q[0].m !== 4'd5) begin errors++; $display("FAIL five_mod got %0d want 5", act_q[0].m); end
        end
    endtask

    task automatic test_gaps;
        int e, ef;
        act_q.delete();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, e);
            if (i < 2) begin
                step(1'b0, 1'b0, 1'b1, e);
                step(1'b0, 1'b0, 1'b1, e);
            end
        end
        step(1'b0, 1'b0, 1'b0, ef);
        idle(3);
        checks++;
        if (act_q.size() !== 1) begin errors++; $display("FAIL gaps_count got %0d want 1", act_q.size()); end
        if (act_q.size() > 0) begin
            checks += 3;
            if (act_q[0].c !== ef) begin errors++; $display("FAIL gaps_cycle got %0d want %0d", act_q[0].c, ef); end
            if (act_q[0].d !== 16'hE000) begin errors++; $display("FAIL gaps_data got %h want e000", act_q[0].d); end
            if (act_q[0].m !== 4'd3) begin errors++; $display("FAIL gaps_mod got %0d want 3", act_q[0].m); end
        end
    endtask

    task automatic test_short_err;
        int e, ef;
        act_q.delete();
        step(1'b1, 1'b1, 1'b1, e);
        step(1'b1, 1'b1, 1'b1, e);
        step(1'b0, 1'b0, 1'b0, ef);
        idle(3);
        checks += 3;
        if (act_q.size() !== 1) begin errors++; $display("FAIL short_count got %0d want 1", act_q.size()); end
        if (bus.deser_data_o !== 16'hE000) begin errors++; $display("FAIL short_hold_data got %h want e000", bus.deser_data_o); end
        if (bus.deser_data_mod_o !== 4'd3) begin errors++; $display("FAIL short_hold_mod got %0d want 3", bus.deser_data_mod_o); end
        if (act_q.size() > 0) begin
            checks += 2;
            if (act_q[0].c !== ef) begin errors++; $display("FAIL short_cycle got %0d want %0d", act_q[0].c, ef); end
            if (act_q[0].e !== 1'b1 || act_q[0].v !== 1'b0) begin errors++; $display("FAIL short_kind got v%b e%b want v0 e1", act_q[0].v, act_q[0].e); end
        end
    endtask

    task automatic test_mid_reset;
        logic [15:0] w = 16'h1234;
        int e, ef;
        act_q.delete();
        for (int i = 0; i < 7; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b1, e);
        @(negedge clk_150m);
        bus.ser_data_val_i = 1'b0;
        bus.busy_i = 1'b0;
        #1 arst_i = 1'b1;
        #1;
        checks += 4;
        if (bus.deser_data_o !== 16'h0) begin errors++; $display("FAIL midrst_data got %h want 0000", bus.deser_data_o); end
        if (bus.deser_data_mod_o !== 4'h0) begin errors++; $display("FAIL midrst_mod got %h want 0", bus.deser_data_mod_o); end
        if (bus.deser_data_val_o !== 1'b0) begin errors++; $display("FAIL midrst_val got %b want 0", bus.deser_data_val_o); end
        if (bus.err_o !== 1'b0) begin errors++; $display("FAIL midrst_err got %b want 0", bus.err_o); end
        @(negedge clk_150m);
        arst_i = 1'b0;
        idle(2);
        for (int i = 0; i < 16; i++) step(1'b1, w[15-i], 1'b1, e);
        ef = e;
        idle(3);
        checks++;
        if (act_q.size() !== 1) begin errors++; $display("FAIL midrst_count got %0d want 1", act_q.size()); end
        if (act_q.size() > 0) begin
            checks += 3;
            if (act_q[0].c !== ef) begin errors++; $display("FAIL midrst_cycle got %0d want %0d", act_q[0].c, ef); end
            if (act_q[0].d !== 16'h1234) begin errors++; $display("FAIL midrst_data2 got %h want 1234", act_q[0].d); end
            if (act_q[0].m !== 4'd0) begin errors++; $display("FAIL midrst_mod2 got %0d want 0", act_q[0].m); end
        end
    endtask

    // serializer-level model: a frame of len = mod (0 -> 16) bits, MSB first, then busy drops
    task automatic ser_send(input logic [15:0] d, input logic [3:0] m, input logic v, input logic drop_busy);
        int e, len;
        logic [15:0] mask;
        if (!v || m == 4'd1 || m == 4'd2) begin
            step(1'b0, 1'b0, 1'b0, e);
            return;
        end
        len  = (m == 4'd0) ? 16 : int'(m);
        mask = 16'hFFFF << (16 - len);
        for (int i = 0; i < len; i++) step(1'b1, d[15-i], 1'b1, e);
        if (len != 16 || drop_busy) step(1'b0, 1'b0, 1'b0, len == 16 ? len : e);
        exp_q.push_back('{e, 1'b1, 1'b0, d & mask, m});
    endtask

    task automatic compare_stream(input string name);
        idle(3);
        checks++;
        if (act_q.size() !== exp_q.size()) begin errors++; $display("FAIL %s_count got %0d want %0d", name, act_q.size(), exp_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act_q[i].c !== exp_q[i].c || act_q[i].v !== 1'b1 || act_q[i].e !== 1'b0 ||
                act_q[i].d !== exp_q[i].d || act_q[i].m !== exp_q[i].m) begin
                errors++;
                $display("FAIL %s[%0d] got c%0d v%b e%b d%h m%0d want c%0d v1 e0 d%h m%0d", name, i,
                         act_q[i].c, act_q[i].v, act_q[i].e, act_q[i].d, act_q[i].m,
                         exp_q[i].c, exp_q[i].d, exp_q[i].m);
            end
        end
    endtask

    task automatic test_back_to_back;
        act_q.delete();
        exp_q.delete();
        ser_send(16'($urandom), 4'd0, 1'b1, 1'b0);
        ser_send(16'($urandom), 4'd0, 1'b1, 1'b0);
        ser_send(16'($urandom), 4'd9, 1'b1, 1'b1);
        compare_stream("b2b");
    endtask

    task automatic test_loopback;
        act_q.delete();
        exp_q.delete();
        ser_send(16'hFFFF, 4'd0, 1'b1, 1'b1);
        ser_send(16'h0000, 4'd0, 1'b1, 1'b1);
        ser_send(16'hFEDC, 4'd1, 1'b1, 1'b1);
        for (int i = 0; i < 50; i++)
            ser_send(16'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
        compare_stream("loop");
    endtask

    initial begin
        bus.ser_data_i     = 1'b0;
        bus.ser_data_val_i = 1'b0;
        bus.busy_i         = 1'b0;
        test_reset;
        test_full;
        test_five;
        test_gaps;
        test_short_err;
        test_mid_reset;
        test_back_to_back;
        test_loopback;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
